// File: rtl/branch_cond_unit_pkg.sv
// Shared flag bit positions and condition-code encodings for branch evaluation.
package branch_cond_unit_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned COND_W = 4;

  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/branch_cond_unit_cond_eval.sv
// Combinational condition-code evaluator: flags + condition -> taken.
module branch_cond_unit_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [FLAG_W-1:0] flags,
  input  logic [COND_W-1:0] cond,
  output logic              taken
);

  logic v, z, n, c;

  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];

  // Decode the condition against the supplied flags
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Architectural flag register plus registered branch-decision stage with valid/ready.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] status_in,
  input  logic              flag_we,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [COND_W-1:0] req_cond,
  input  logic [ADDR_W-1:0] req_target,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_taken,
  output logic [ADDR_W-1:0] rsp_target,
  output logic [FLAG_W-1:0] flags_q,
  output logic [CNT_W-1:0]  taken_cnt
);

  logic [FLAG_W-1:0] eff_flags;
  logic              eval_taken;
  logic              accept;
  logic              deliver_taken;

  // Same-cycle flag writes bypass the register so the new status is evaluated
  assign eff_flags     = flag_we ? status_in : flags_q;
  assign req_ready     = ~rsp_valid | rsp_ready;
  assign accept        = req_valid & req_ready;
  assign deliver_taken = rsp_valid & rsp_ready & rsp_taken;

  branch_cond_unit_cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (req_cond),
    .taken (eval_taken)
  );

  // Flag register update
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (flag_we) begin
      flags_q <= status_in;
    end
  end

  // Single-entry response register; payload holds while stalled or drained
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_taken  <= 1'b0;
      rsp_target <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_taken  <= eval_taken;
      rsp_target <= req_target;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  // Saturating count of taken decisions handed to the consumer
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt <= '0;
    end else if (deliver_taken && (taken_cnt != {CNT_W{1'b1}})) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed self-checking bench for branch_cond_unit.
module tb_branch_cond_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 3;

  logic              clk;
  logic              reset;
  logic [3:0]        status_in;
  logic              flag_we;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cond;
  logic [ADDR_W-1:0] req_target;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_taken;
  logic [ADDR_W-1:0] rsp_target;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  taken_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_cond_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .status_in  (status_in),
    .flag_we    (flag_we),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cond   (req_cond),
    .req_target (req_target),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_taken  (rsp_taken),
    .rsp_target (rsp_target),
    .flags_q    (flags_q),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Condition table written straight from the flag definitions: f = {V,Z,N,C}
  function automatic logic ref_taken(input logic [3:0] f, input logic [3:0] c);
    logic v, z, n, cy;
    v = f[3]; z = f[2]; n = f[1]; cy = f[0];
    if (c == 4'd0)       return z;
    else if (c == 4'd1)  return !z;
    else if (c == 4'd2)  return cy;
    else if (c == 4'd3)  return !cy;
    else if (c == 4'd4)  return n;
    else if (c == 4'd5)  return !n;
    else if (c == 4'd6)  return v;
    else if (c == 4'd7)  return !v;
    else if (c == 4'd8)  return cy && !z;
    else if (c == 4'd9)  return !cy || z;
    else if (c == 4'd10) return n == v;
    else if (c == 4'd11) return n != v;
    else if (c == 4'd12) return !z && (n == v);
    else if (c == 4'd13) return z || (n != v);
    else if (c == 4'd14) return 1'b1;
    else                 return 1'b0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    status_in  = '0;
    flag_we    = 1'b0;
    req_valid  = 1'b0;
    req_cond   = '0;
    req_target = '0;
    rsp_ready  = 1'b1;

    // Reset state
    do_reset();
    check("rst_flags", 32'(flags_q), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_taken", 32'(rsp_taken), 32'h0);
    check("rst_rsp_target", rsp_target, 32'h0);
    check("rst_taken_cnt", 32'(taken_cnt), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);

    // Load Z, then EQ uses the registered flags
    flag_we = 1'b1; status_in = 4'b0100;
    step();
    flag_we = 1'b0;
    check("load_flags", 32'(flags_q), 32'h4);
    check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    req_valid = 1'b1; req_cond = 4'd0; req_target = 32'h0000_1000;
    step();
    req_valid = 1'b0;
    check("eq_rsp_valid", 32'(rsp_valid), 32'h1);
    check("eq_rsp_taken", 32'(rsp_taken), 32'h1);
    check("eq_rsp_target", rsp_target, 32'h0000_1000);
    check("eq_cnt_before", 32'(taken_cnt), 32'h0);

    // Bypass: same-cycle flag write clears Z for the decision
    flag_we = 1'b1; status_in = 4'b0000;
    req_valid = 1'b1; req_cond = 4'd0; req_target = 32'h0000_2000;
    step();
    check("byp_rsp_taken", 32'(rsp_taken), 32'h0);
    check("byp_rsp_target", rsp_target, 32'h0000_2000);
    check("byp_flags", 32'(flags_q), 32'h0);
    check("byp_cnt", 32'(taken_cnt), 32'h1);

    // Full sweep of conditions against flag values, back-to-back via bypass
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        flag_we = 1'b1; status_in = 4'(f);
        req_valid = 1'b1; req_cond = 4'(c); req_target = 32'(f * 16 + c) + 32'hA000_0000;
        step();
        check($sformatf("sweep_taken_f%0h_c%0h", f, c), 32'(rsp_taken), 32'(ref_taken(4'(f), 4'(c))));
        check($sformatf("sweep_tgt_f%0h_c%0h", f, c), rsp_target, 32'(f * 16 + c) + 32'hA000_0000);
      end
    end
    flag_we = 1'b0; req_valid = 1'b0;

    // Backpressure: held decision survives flag writes, queued request waits
    do_reset();
    req_valid = 1'b1; req_cond = 4'd14; req_target = 32'h0000_00A1;
    step();
    rsp_ready = 1'b0;
    req_cond = 4'd15; req_target = 32'h0000_00B2;
    for (int i = 0; i < 3; i++) begin
      flag_we = (i % 2 == 0); status_in = 4'hF;
      step();
      check($sformatf("hold_req_ready_%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("hold_rsp_valid_%0d", i), 32'(rsp_valid), 32'h1);
      check($sformatf("hold_rsp_taken_%0d", i), 32'(rsp_taken), 32'h1);
      check($sformatf("hold_rsp_target_%0d", i), rsp_target, 32'h0000_00A1);
    end
    check("hold_flags", 32'(flags_q), 32'hF);
    check("hold_cnt", 32'(taken_cnt), 32'h0);
    flag_we = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("release_req_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 1'b0;
    check("release_rsp_valid", 32'(rsp_valid), 32'h1);
    check("release_rsp_taken", 32'(rsp_taken), 32'h0);
    check("release_rsp_target", rsp_target, 32'h0000_00B2);
    check("release_cnt", 32'(taken_cnt), 32'h1);
    step();
    check("drain_rsp_valid", 32'(rsp_valid), 32'h0);
    check("drain_rsp_target", rsp_target, 32'h0000_00B2);
    check("drain_cnt", 32'(taken_cnt), 32'h1);

    // Back-to-back AL,NV,AL,AL at full throughput
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_cond = (k == 1) ? 4'd15 : 4'd14;
      req_target = 32'h0000_0100 + 32'(k);
      step();
      check($sformatf("b2b_valid_%0d", k), 32'(rsp_valid), 32'h1);
      check($sformatf("b2b_taken_%0d", k), 32'(rsp_taken), (k == 1) ? 32'h0 : 32'h1);
      check($sformatf("b2b_target_%0d", k), rsp_target, 32'h0000_0100 + 32'(k));
    end
    req_valid = 1'b0;
    step();
    check("b2b_done_valid", 32'(rsp_valid), 32'h0);
    check("b2b_cnt", 32'(taken_cnt), 32'h3);

    // Reach taken_cnt=5 with a response pending, then reset
    req_valid = 1'b1; req_cond = 4'd14;
    step();
    step();
    step();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("pre_rst_valid", 32'(rsp_valid), 32'h1);
    check("pre_rst_cnt", 32'(taken_cnt), 32'h5);
    reset = 1'b1; flag_we = 1'b1; status_in = 4'hF;
    step();
    reset = 1'b0; flag_we = 1'b0;
    check("mid_rst_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_cnt", 32'(taken_cnt), 32'h0);
    check("mid_rst_flags", 32'(flags_q), 32'h0);
    check("mid_rst_req_ready", 32'(req_ready), 32'h1);

    // Saturation: 10 taken responses into a 3-bit counter stops at 7
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_cond = 4'd14;
    for (int k = 0; k < 10; k++) step();
    req_valid = 1'b0;
    step();
    check("sat_cnt", 32'(taken_cnt), 32'h7);
    check("sat_valid", 32'(rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
